// File: rtl/buzzer_scheduler_if.sv
// Request/grant bundle between the three tone requesters and the buzzer scheduler.
// master = requester side, slave = scheduler side.
interface buzzer_scheduler_if #(
   parameter int DIV_W = 21,
   parameter int DUR_W = 4
);
   logic [2:0]       iREQ;
   logic [DIV_W-1:0] iDIV0;
   logic [DIV_W-1:0] iDIV1;
   logic [DIV_W-1:0] iDIV2;
   logic [DUR_W-1:0] iDUR0;
   logic [DUR_W-1:0] iDUR1;
   logic [DUR_W-1:0] iDUR2;
   logic [2:0]       oGNT;
   logic [2:0]       oDONE;
   logic [2:0]       oABORT;
   logic             oBUSY;
   logic             oSOUND;

   modport master (
      output iREQ, iDIV0, iDIV1, iDIV2, iDUR0, iDUR1, iDUR2,
      input  oGNT, oDONE, oABORT, oBUSY, oSOUND
   );

   modport slave (
      input  iREQ, iDIV0, iDIV1, iDIV2, iDUR0, iDUR1, iDUR2,
      output oGNT, oDONE, oABORT, oBUSY, oSOUND
   );
endinterface

// File: rtl/buzzer_scheduler.sv
// Fixed-priority, preemptive sharing of one piezo buzzer among three requesters.
// Each grant plays one square-wave note for dur ticks, then a silent rest.
module buzzer_scheduler #(
   parameter int TICK_DIV  = 6_250_000,
   parameter int DIV_W     = 21,
   parameter int DUR_W     = 4,
   parameter int GAP_TICKS = 1
) (
   input logic               iCLK,
   input logic               iRST_N,
   buzzer_scheduler_if.slave bus
);
   localparam int REST_CYC = (GAP_TICKS * TICK_DIV < 2) ? 2 : GAP_TICKS * TICK_DIV;
   localparam int TW       = $clog2(TICK_DIV);
   localparam int RW       = $clog2(REST_CYC);

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_REST} state_t;

   state_t           state_q;
   logic [2:0]       gnt_q;
   logic [2:0]       done_q;
   logic [2:0]       abort_q;
   logic             busy_q;
   logic             sound_q;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] hp_q;
   logic [DUR_W-1:0] dur_q;
   logic [DUR_W-1:0] dur_cnt_q;
   logic [TW-1:0]    tick_q;
   logic [RW-1:0]    rest_q;

   logic [2:0]       win_oh;
   logic [DIV_W-1:0] win_div;
   logic [DUR_W-1:0] win_dur;
   logic             tick_wrap;
   logic             note_end;
   logic             preempt;
   logic             owner_req;
   logic             start;

   always_comb begin
      win_oh  = 3'b000;
      win_div = bus.iDIV0;
      win_dur = bus.iDUR0;
      if (bus.iREQ[0]) begin
         win_oh = 3'b001;
      end else if (bus.iREQ[1]) begin
         win_oh  = 3'b010;
         win_div = bus.iDIV1;
         win_dur = bus.iDUR1;
      end else if (bus.iREQ[2]) begin
         win_oh  = 3'b100;
         win_div = bus.iDIV2;
         win_dur = bus.iDUR2;
      end
      if (win_dur == '0) begin
         win_dur = DUR_W'(1);
      end
      tick_wrap = (tick_q == TW'(TICK_DIV - 1));
      note_end  = tick_wrap && (dur_cnt_q == dur_q - DUR_W'(1));
      // gnt_q is one-hot in PLAY, so gnt_q-1 masks exactly the higher-priority bits
      preempt   = |(bus.iREQ & (gnt_q - 3'b001));
      owner_req = |(bus.iREQ & gnt_q);
      start     = ((state_q == S_IDLE) && (|bus.iREQ)) ||
                  ((state_q == S_PLAY) && !note_end && preempt);
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q   <= S_IDLE;
         gnt_q     <= '0;
         done_q    <= '0;
         abort_q   <= '0;
         busy_q    <= 1'b0;
         sound_q   <= 1'b0;
         div_q     <= '0;
         hp_q      <= '0;
         dur_q     <= '0;
         dur_cnt_q <= '0;
         tick_q    <= '0;
         rest_q    <= '0;
      end else begin
         done_q  <= '0;
         abort_q <= '0;
         unique case (state_q)
            S_IDLE: begin
            end
            S_PLAY: begin
               if (note_end) begin
                  done_q  <= gnt_q;
                  gnt_q   <= '0;
                  sound_q <= 1'b0;
                  rest_q  <= '0;
                  state_q <= S_REST;
               end else if (preempt) begin
                  abort_q <= gnt_q;
               end else if (!owner_req) begin
                  abort_q <= gnt_q;
                  gnt_q   <= '0;
                  sound_q <= 1'b0;
                  rest_q  <= '0;
                  state_q <= S_REST;
               end else begin
                  tick_q <= tick_wrap ? '0 : tick_q + TW'(1);
                  if (tick_wrap) begin
                     dur_cnt_q <= dur_cnt_q + DUR_W'(1);
                  end
                  if (div_q != '0) begin
                     if (hp_q == div_q - DIV_W'(1)) begin
                        hp_q    <= '0;
                        sound_q <= ~sound_q;
                     end else begin
                        hp_q <= hp_q + DIV_W'(1);
                     end
                  end
               end
            end
            S_REST: begin
               if (rest_q == RW'(REST_CYC - 1)) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  rest_q <= rest_q + RW'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
         // A fresh grant (from IDLE or by preemption) overrides the per-state updates above
         if (start) begin
            state_q   <= S_PLAY;
            gnt_q     <= win_oh;
            busy_q    <= 1'b1;
            sound_q   <= 1'b0;
            div_q     <= win_div;
            dur_q     <= win_dur;
            hp_q      <= '0;
            dur_cnt_q <= '0;
            tick_q    <= '0;
         end
      end
   end

   assign bus.oGNT   = gnt_q;
   assign bus.oDONE  = done_q;
   assign bus.oABORT = abort_q;
   assign bus.oBUSY  = busy_q;
   assign bus.oSOUND = sound_q;
endmodule

// File: tb/tb_buzzer_scheduler.sv
// Bench for buzzer_scheduler: directed scenarios then random requesters,
// every cycle compared against a note-level reference model.
module tb_buzzer_scheduler;
   localparam int TD       = 10;
   localparam int GAP      = 1;
   localparam int DIV_W    = 21;
   localparam int DUR_W    = 4;
   localparam int REST_CYC = (GAP * TD < 2) ? 2 : GAP * TD;

   logic clk;
   logic rst_n;

   buzzer_scheduler_if #(.DIV_W(DIV_W), .DUR_W(DUR_W)) bus ();

   buzzer_scheduler #(
      .TICK_DIV (TD),
      .DIV_W    (DIV_W),
      .DUR_W    (DUR_W),
      .GAP_TICKS(GAP)
   ) dut (
      .iCLK  (clk),
      .iRST_N(rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // reference model: note-level view (phase, owner, elapsed play cycles)
   int         m_phase;
   int         m_own;
   int         m_div;
   int         m_dur;
   int         m_j;
   int         m_rest;
   logic [2:0] e_gnt;
   logic [2:0] e_done;
   logic [2:0] e_abort;
   logic       e_busy;
   logic       e_sound;

   bit   rand_en;
   int   rise_cnt;
   int   done2_cnt;
   logic prev_sound;

   function automatic int lowest(input logic [2:0] r);
      for (int i = 0; i < 3; i++) begin
         if (r[i]) return i;
      end
      return -1;
   endfunction

   function automatic int req_div(input int n);
      case (n)
         0:       return int'(bus.iDIV0);
         1:       return int'(bus.iDIV1);
         default: return int'(bus.iDIV2);
      endcase
   endfunction

   function automatic int req_dur(input int n);
      case (n)
         0:       return int'(bus.iDUR0);
         1:       return int'(bus.iDUR1);
         default: return int'(bus.iDUR2);
      endcase
   endfunction

   task automatic model_reset();
      m_phase = 0; m_own = 0; m_div = 0; m_dur = 0; m_j = 0; m_rest = 0;
      e_gnt = '0; e_done = '0; e_abort = '0; e_busy = 1'b0; e_sound = 1'b0;
   endtask

   task automatic model_start(input int w);
      m_own   = w;
      m_div   = req_div(w);
      m_dur   = (req_dur(w) == 0) ? 1 : req_dur(w);
      m_j     = 0;
      m_phase = 1;
      e_gnt   = 3'b001 << w;
      e_busy  = 1'b1;
      e_sound = 1'b0;
   endtask

   task automatic model_rest();
      m_phase = 2; m_rest = 0; e_gnt = '0; e_sound = 1'b0;
   endtask

   task automatic model_step();
      int w;
      if (!rst_n) begin
         model_reset();
         return;
      end
      e_done  = '0;
      e_abort = '0;
      w = lowest(bus.iREQ);
      case (m_phase)
         0: if (w >= 0) model_start(w);
         1: begin
            m_j++;
            if (m_j == m_dur * TD) begin
               e_done[m_own] = 1'b1;
               model_rest();
            end else if (w >= 0 && w < m_own) begin
               e_abort[m_own] = 1'b1;
               model_start(w);
            end else if (!bus.iREQ[m_own]) begin
               e_abort[m_own] = 1'b1;
               model_rest();
            end else begin
               e_sound = (m_div != 0) && (((m_j / m_div) % 2) == 1);
            end
         end
         default: begin
            m_rest++;
            if (m_rest == REST_CYC) begin
               m_phase = 0;
               e_busy  = 1'b0;
            end
         end
      endcase
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
   endtask

   task automatic set_req(input int n, input int d, input int u);
      case (n)
         0: begin bus.iDIV0 = DIV_W'(d); bus.iDUR0 = DUR_W'(u); end
         1: begin bus.iDIV1 = DIV_W'(d); bus.iDUR1 = DUR_W'(u); end
         default: begin bus.iDIV2 = DIV_W'(d); bus.iDUR2 = DUR_W'(u); end
      endcase
      bus.iREQ[n] = 1'b1;
   endtask

   function automatic logic [10:0] outs();
      return {bus.oGNT, bus.oDONE, bus.oABORT, bus.oBUSY, bus.oSOUND};
   endfunction

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("outs", 32'(outs()), 32'({e_gnt, e_done, e_abort, e_busy, e_sound}));
      if (bus.oSOUND && !prev_sound) rise_cnt++;
      prev_sound = bus.oSOUND;
      if (bus.oDONE[2]) done2_cnt++;
      for (int n = 0; n < 3; n++) begin
         if (bus.iREQ[n] && (e_done[n] || e_abort[n])) begin
            bus.iREQ[n] = 1'b0;
         end else if (rand_en && !bus.iREQ[n] && $urandom_range(0, 7) == 0) begin
            set_req(n, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
         end else if (rand_en && bus.iREQ[n] && m_phase == 1 && m_own == n &&
                      $urandom_range(0, 39) == 0) begin
            bus.iREQ[n] = 1'b0;
         end
      end
   endtask

   task automatic run(input int k);
      repeat (k) cycle();
   endtask

   initial begin
      rst_n = 1'b0;
      rand_en = 1'b0;
      rise_cnt = 0; done2_cnt = 0; prev_sound = 1'b0;
      bus.iREQ = '0;
      bus.iDIV0 = '0; bus.iDIV1 = '0; bus.iDIV2 = '0;
      bus.iDUR0 = '0; bus.iDUR1 = '0; bus.iDUR2 = '0;
      model_reset();
      #2;
      check("reset_outs", 32'(outs()), 32'd0);
      run(2);
      rst_n = 1'b1;

      // single low-priority note: div 3, two ticks
      rise_cnt = 0; done2_cnt = 0;
      set_req(2, 3, 2);
      run(1);
      check("A_gnt", 32'(bus.oGNT), 32'(3'b100));
      run(34);
      check("A_rises", rise_cnt, 3);
      check("A_done2", done2_cnt, 1);

      // two simultaneous requests, bit 1 first then bit 2
      set_req(1, 2, 1);
      set_req(2, 4, 1);
      run(1);
      check("B_gnt", 32'(bus.oGNT), 32'(3'b010));
      run(45);

      // preemption of a long note by bit 0
      set_req(2, 2, 5);
      run(13);
      set_req(0, 1, 2);
      run(1);
      check("C_gnt", 32'(bus.oGNT), 32'(3'b001));
      check("C_abort", 32'(bus.oABORT), 32'(3'b100));
      run(40);

      // silent note with zero duration
      rise_cnt = 0;
      set_req(1, 0, 0);
      run(25);
      check("D_rises", rise_cnt, 0);

      // owner cancels mid-note
      set_req(0, 5, 3);
      run(12);
      bus.iREQ[0] = 1'b0;
      run(1);
      check("E_abort", 32'(bus.oABORT), 32'(3'b001));
      run(14);

      // asynchronous reset mid-note, request held through reset
      set_req(2, 2, 5);
      run(7);
      rst_n = 1'b0;
      #1;
      check("F_rst", 32'(outs()), 32'd0);
      model_reset();
      run(2);
      rst_n = 1'b1;
      run(1);
      check("F_regnt", 32'(bus.oGNT), 32'(3'b100));
      run(70);

      rand_en = 1'b1;
      run(3000);
      rand_en = 1'b0;
      run(200);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
